debug_link_slave: RTL
=====================

Name: debug_link_slave

Overview:
- Slave end of the MicroBlaze-to-MIPS debug link, instanced inside the Mips core.
- Consumes the software-toggled GPIO signals: MOSI payload, SCLK strobe, SPI chip-select command code, valid and continue.
- Turns them into instruction-memory write pulses, a run level, single-step pulses and debug-read selects, and returns readback or status on o_MISO.

Parameters:
- NB_BITS, 32, data and readback width.
- NB_MOSI, 25, MOSI payload width.
- NB_CS, 4, command code width.
- NB_ADDR, 10, instruction-memory address width (at most 16).
- NB_SEL, 8, debug readback selector width.

Ports:
- i_clk, in, 1: core clock (clk50 domain).
- i_rst, in, 1: asynchronous, active-low reset.
- i_MOSI, in, NB_MOSI: command payload.
- i_SCLK, in, 1: command strobe; its rising edge executes the command.
- i_SPI_cs, in, NB_CS: command code.
- i_valid, in, 1: single-step request; acts on its rising edge.
- i_continue, in, 1: run-mode level.
- i_dbg_data, in, NB_BITS: debug value selected by o_dbg_sel (combinational, from the core).
- i_halted, in, 1: core halted flag.
- o_MISO, out, NB_BITS: readback word.
- o_imem_we, out, 1: instruction-memory write pulse.
- o_imem_addr, out, NB_ADDR: write address.
- o_imem_data, out, NB_BITS: write data.
- o_dbg_sel, out, NB_SEL: debug readback selector.
- o_run, out, 1: free-run enable.
- o_step, out, 1: single-step pulse.

Behaviour:
- Reset (i_rst=0, async): every output 0; pointer=0, data latch=0, err=0, mode=STATUS.
- Synchronisers:
  - i_SCLK, i_valid, i_continue each pass through 2 flops plus a history flop.
  - rise = s1 & ~s2.
  - A level first sampled high at edge k gives a registered action at edge k+2.
- Qualified inputs: i_MOSI and i_SPI_cs are only sampled in the sclk_rise cycle. Software holds them stable across the strobe.
- Command decode on sclk_rise, using i_SPI_cs:
  - 0 NOP: no effect.
  - 1 ADDR: pointer <= MOSI[NB_ADDR-1:0].
  - 2 DLO: data[15:0] <= MOSI[15:0].
  - 3 DHI_WR, o_run=0: data[31:16] <= MOSI[15:0]. At the same edge: o_imem_we=1 for exactly 1 cycle, o_imem_addr=pointer, o_imem_data={MOSI[15:0],data[15:0]}, pointer <= pointer+1.
  - 3 DHI_WR, o_run=1: no write, no increment, err <= 1 (sticky).
  - 4 RDSEL: o_dbg_sel <= MOSI[NB_SEL-1:0]; mode <= READ.
  - 5 STAT: mode <= STATUS.
  - 6 CLR: err <= 0.
  - 7..15: ignored, no state change.
- Pointer arithmetic: increments modulo 2^NB_ADDR, so 2^NB_ADDR-1 wraps to 0.
- MOSI bits above those each command uses are ignored.
- o_MISO is re-registered every cycle:
  - READ mode: i_dbg_data, so readback is valid one cycle after o_dbg_sel updates (edge k+3).
  - STATUS mode: {i_halted, err, o_run, 13'b0, pointer zero-extended to 16}.
- o_run <= synchronised i_continue (level, same latency as above).
- o_step:
  - 1-cycle pulse on a valid rise, only when o_run=0 and the synchronised i_continue=0.
  - Otherwise the valid rise is dropped, with no queueing.
- Simultaneous events: a step and a command in the same cycle are both executed; they are independent.
- o_imem_we is never high in two consecutive cycles.
- Reset mid-operation: any pending pulse is cancelled, and the first command after reset release needs a fresh SCLK rise.
- FSM (mode) states:
  - STATUS->READ on cs=4.
  - READ->STATUS on cs=5 or reset.
  - All other commands leave mode unchanged.

Decomposition:
- Package dbg_link_pkg holds:
  - command code constants CMD_NOP..CMD_CLR (0..6);
  - the mode encoding (MODE_STATUS=0, MODE_READ=1);
  - status bit positions (HALT=31, ERR=30, RUN=29).
- Sub-module sync_rise: 2-flop synchroniser, history flop and rise output, with async active-low reset. Instanced three times, for SCLK, valid and continue; only the level output is used for continue.

Test Plan:
- Reset release, no stimulus -> all outputs 0; a STAT read gives o_MISO=0x00000000 with i_halted=0.
- ADDR 0x010; DLO 0xBEEF; DHI_WR 0xDEAD -> one o_imem_we pulse, addr=0x010, data=0xDEADBEEF at edge k+2; STAT shows pointer 0x011.
- ADDR 0x3FF, then two DHI_WR -> writes at 0x3FF and 0x000 (wrap); o_imem_we low between the pulses.
- i_continue=1, then DHI_WR -> no o_imem_we; STAT shows bits 30 and 29 set (0x60000000 | pointer); CLR then clears bit 30.
- RDSEL 0x05 with i_dbg_data=0x12345678 -> o_dbg_sel=0x05 at edge k+2, o_MISO=0x12345678 at edge k+3; changing i_dbg_data is tracked on the next cycle.
- i_valid rise with i_continue=0 -> exactly one o_step pulse; i_valid held high gives no further pulses; with i_continue=1, no pulse. Assert i_rst mid-sequence -> all outputs clear immediately.

Source files
------------

// File: rtl/dbg_link_pkg.sv
// rtl/dbg_link_pkg.sv - shared command codes, mode encoding and status layout for the debug link
package dbg_link_pkg;

    localparam logic [3:0] CMD_NOP    = 4'd0;
    localparam logic [3:0] CMD_ADDR   = 4'd1;
    localparam logic [3:0] CMD_DLO    = 4'd2;
    localparam logic [3:0] CMD_DHI_WR = 4'd3;
    localparam logic [3:0] CMD_RDSEL  = 4'd4;
    localparam logic [3:0] CMD_STAT   = 4'd5;
    localparam logic [3:0] CMD_CLR    = 4'd6;

    typedef enum logic {
        MODE_STATUS = 1'b0,
        MODE_READ   = 1'b1
    } mode_e;

    localparam int ST_HALT = 31;
    localparam int ST_ERR  = 30;
    localparam int ST_RUN  = 29;

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - two-flop synchroniser with history flop and rising-edge output
module sync_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    // meta -> sync resolves metastability, hist keeps the previous synchronised level
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign o_level = sync_q;
    assign o_rise  = sync_q & ~hist_q;

endmodule

// File: rtl/debug_link_slave.sv
// rtl/debug_link_slave.sv - GPIO-driven debug link slave: imem loader, run/step control, readback
module debug_link_slave
    import dbg_link_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_MOSI = 25,
    parameter int NB_CS   = 4,
    parameter int NB_ADDR = 10,
    parameter int NB_SEL  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_MOSI-1:0] i_MOSI,
    input  logic               i_SCLK,
    input  logic [NB_CS-1:0]   i_SPI_cs,
    input  logic               i_valid,
    input  logic               i_continue,
    input  logic [NB_BITS-1:0] i_dbg_data,
    input  logic               i_halted,
    output logic [NB_BITS-1:0] o_MISO,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [NB_BITS-1:0] o_imem_data,
    output logic [NB_SEL-1:0]  o_dbg_sel,
    output logic               o_run,
    output logic               o_step
);

    localparam int HALF = NB_BITS / 2;

    logic sclk_rise;
    logic sclk_level_unused;
    logic valid_rise;
    logic valid_level_unused;
    logic cont_level;
    logic cont_rise_unused;

    sync_rise u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_SCLK),
        .o_level (sclk_level_unused),
        .o_rise  (sclk_rise)
    );

    sync_rise u_sync_valid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_valid),
        .o_level (valid_level_unused),
        .o_rise  (valid_rise)
    );

    sync_rise u_sync_cont (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_d     (i_continue),
        .o_level (cont_level),
        .o_rise  (cont_rise_unused)
    );

    mode_e              mode_q;
    logic [NB_ADDR-1:0] ptr_q;
    logic [HALF-1:0]    data_lo_q;
    logic               err_q;
    logic [NB_SEL-1:0]  sel_q;
    logic               we_q;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_BITS-1:0] wdata_q;
    logic               run_q;
    logic               step_q;
    logic [NB_BITS-1:0] miso_q;
    logic [NB_BITS-1:0] status_d;

    // command decoder and readback-mode FSM; acts only on a synchronised SCLK rise
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mode_q    <= MODE_STATUS;
            ptr_q     <= '0;
            data_lo_q <= '0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (sclk_rise) begin
                case (i_SPI_cs)
                    CMD_ADDR: ptr_q <= i_MOSI[NB_ADDR-1:0];
                    CMD_DLO:  data_lo_q <= i_MOSI[HALF-1:0];
                    CMD_DHI_WR: begin
                        // loading imem while the core free-runs is refused and flagged
                        if (!run_q) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q;
                            wdata_q <= {i_MOSI[HALF-1:0], data_lo_q};
                            ptr_q   <= ptr_q + NB_ADDR'(1);
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    CMD_RDSEL: begin
                        sel_q  <= i_MOSI[NB_SEL-1:0];
                        mode_q <= MODE_READ;
                    end
                    CMD_STAT: mode_q <= MODE_STATUS;
                    CMD_CLR:  err_q <= 1'b0;
                    default:  ;
                endcase
            end
        end
    end

    // status word: halted/err/run flags on top, load pointer in the low half
    always_comb begin
        status_d                = '0;
        status_d[NB_ADDR-1:0]   = ptr_q;
        status_d[ST_HALT]       = i_halted;
        status_d[ST_ERR]        = err_q;
        status_d[ST_RUN]        = run_q;
    end

    // run level, single-step pulse and readback register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            run_q  <= 1'b0;
            step_q <= 1'b0;
            miso_q <= '0;
        end else begin
            run_q  <= cont_level;
            step_q <= valid_rise & ~run_q & ~cont_level;
            miso_q <= (mode_q == MODE_READ) ? i_dbg_data : status_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{i_MOSI[NB_MOSI-1:HALF], cont_rise_unused,
                         sclk_level_unused, valid_level_unused};

    assign o_MISO      = miso_q;
    assign o_imem_we   = we_q;
    assign o_imem_addr = addr_q;
    assign o_imem_data = wdata_q;
    assign o_dbg_sel   = sel_q;
    assign o_run       = run_q;
    assign o_step      = step_q;

endmodule
